// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-write buffer between the cache memory port and main memory.
// Writes are acknowledged once queued and retired in FIFO order; reads may overtake
// queued writes unless a queued or in-flight write targets the same word.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   rw_flag, addr            upstream request ([0] read wins over [1] write), word address
//   write_data, write_mask   upstream write payload and byte enables
//   read_data, busy, done    upstream read result, request-held flag, completion pulse
//   empty                    nothing queued and no downstream write outstanding
//   mem_rw_flag, mem_addr    downstream one-cycle request pulse (1 read, 2 write)
//   mem_write_data/mask      downstream write payload
//   mem_read_data            downstream read data, valid with mem_done
//   mem_busy, mem_done       downstream back-pressure and completion pulse
`timescale 1ns/1ps

module mem_write_buffer #(
    parameter int DEPTH       = 4,
    parameter bit READ_BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  rw_flag,
    input  logic [31:0] addr,
    output logic [31:0] read_data,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    output logic        busy,
    output logic        done,
    output logic        empty,
    output logic [1:0]  mem_rw_flag,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    input  logic        mem_busy,
    input  logic        mem_done
);

    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_WRITE = 2'd1,
        WAIT_READ  = 2'd2
    } state_t;

    state_t state;

    logic [31:0]      f_addr [DEPTH];
    logic [31:0]      f_data [DEPTH];
    logic [3:0]       f_mask [DEPTH];
    logic [DEPTH-1:0] f_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic             pend_valid;
    logic             pend_rd;
    logic [31:0]      pend_addr;
    logic [31:0]      pend_data;
    logic [3:0]       pend_mask;

    // word address of the write currently outstanding downstream
    logic [29:0]      out_word;

    logic             accept;
    logic             acc_rd;
    logic             acc_wr;
    logic             full;
    logic             enq_direct;
    logic             enq_pend;
    logic             enq;
    logic             pop;
    logic [31:0]      enq_addr;
    logic [31:0]      enq_data;
    logic [3:0]       enq_mask;
    logic             rd_req;
    logic [31:0]      rd_addr;
    logic             addr_hit;
    logic             hazard;

    assign accept     = !busy && (rw_flag != 2'b00);
    assign acc_rd     = accept && rw_flag[0];
    assign acc_wr     = accept && !rw_flag[0];
    assign full       = (count == FULL);
    assign enq_direct = acc_wr && !full;
    // a parked write enters the queue once a retirement has freed a slot
    assign enq_pend   = pend_valid && !pend_rd && !full;
    assign enq        = enq_direct || enq_pend;
    assign enq_addr   = enq_pend ? pend_addr : addr;
    assign enq_data   = enq_pend ? pend_data : write_data;
    assign enq_mask   = enq_pend ? pend_mask : write_mask;
    assign pop        = (state == WAIT_WRITE) && mem_done;

    // a read accepted this cycle is considered immediately so it can issue next cycle
    assign rd_req  = (pend_valid && pend_rd) || acc_rd;
    assign rd_addr = (pend_valid && pend_rd) ? pend_addr : addr;

    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (f_valid[i] && (f_addr[i][31:2] == rd_addr[31:2]))
                addr_hit = 1'b1;
        end
        if ((state == WAIT_WRITE) && (out_word == rd_addr[31:2]))
            addr_hit = 1'b1;
    end

    assign hazard = READ_BYPASS ? addr_hit
                                : ((count != '0) || (state == WAIT_WRITE));

    assign empty = (count == '0) && (state != WAIT_WRITE);

    // entry payload needs no reset; f_valid qualifies it
    always_ff @(posedge CLK) begin
        if (enq) begin
            f_addr[tail] <= enq_addr;
            f_data[tail] <= enq_data;
            f_mask[tail] <= enq_mask;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            f_valid        <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            pend_valid     <= 1'b0;
            pend_rd        <= 1'b0;
            pend_addr      <= '0;
            pend_data      <= '0;
            pend_mask      <= '0;
            out_word       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            read_data      <= '0;
            mem_rw_flag    <= 2'd0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= '0;
        end else begin
            done           <= 1'b0;
            mem_rw_flag    <= 2'd0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= '0;

            if (pop) begin
                f_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (enq) begin
                f_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            unique case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (enq_direct)
                done <= 1'b1;

            if (acc_rd || (acc_wr && full)) begin
                pend_valid <= 1'b1;
                pend_rd    <= acc_rd;
                pend_addr  <= addr;
                pend_data  <= write_data;
                pend_mask  <= write_mask;
                busy       <= 1'b1;
            end

            if (enq_pend) begin
                pend_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!mem_busy) begin
                        if (rd_req && !hazard) begin
                            mem_rw_flag <= 2'd1;
                            mem_addr    <= rd_addr;
                            state       <= WAIT_READ;
                        end else if (count != '0) begin
                            mem_rw_flag    <= 2'd2;
                            mem_addr       <= f_addr[head];
                            mem_write_data <= f_data[head];
                            mem_write_mask <= f_mask[head];
                            out_word       <= f_addr[head][31:2];
                            state          <= WAIT_WRITE;
                        end
                    end
                end
                WAIT_WRITE: begin
                    if (mem_done)
                        state <= IDLE;
                end
                WAIT_READ: begin
                    if (mem_done) begin
                        read_data  <= mem_read_data;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        pend_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer between the cache's memory port (upstream) and the main memory interface (downstream).
- Writes from the cache are acknowledged as soon as they are queued and retired to memory in FIFO order in the background.
- Reads bypass queued writes unless a queued write targets the same word, in which case the read waits until that write has retired.
- Both sides use the same pulse protocol: `rw_flag`/`busy`/`done` upstream and `mem_rw_flag`/`mem_busy`/`mem_done` downstream.

Parameters:
- DEPTH, 4, number of write entries (power of two, ≥2).
- READ_BYPASS, 1, 1 = a non-conflicting read may overtake queued writes; 0 = every read waits until the buffer is empty.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- rw_flag  in  2  upstream request: [0] read, [1] write. Sampled every cycle where busy=0. Bit 0 wins if both are set.
- addr  in  32  upstream word address. Bits [1:0] are ignored for matching and forwarded unchanged.
- read_data  out  32  read result, valid in the cycle where done=1.
- write_data  in  32  upstream write data.
- write_mask  in  4  upstream byte enables.
- busy  out  1  request held; new requests are ignored.
- done  out  1  one-cycle completion pulse.
- empty  out  1  no queued entries and no downstream write outstanding.
- mem_rw_flag  out  2  downstream one-cycle request pulse: 1 = read, 2 = write.
- mem_addr  out  32  downstream address.
- mem_read_data  in  32  downstream read data, valid while mem_done=1.
- mem_write_data  out  32  downstream write data.
- mem_write_mask  out  4  downstream byte enables.
- mem_busy  in  1  memory cannot accept a request.
- mem_done  in  1  one-cycle pulse completing the outstanding downstream request.

Behaviour:
- Reset values:
  - busy=0, done=0, empty=1, read_data=0.
  - All mem_* outputs are 0.
  - FIFO pointers and count are 0; all entries are invalid; the pending register is cleared; the FSM is IDLE.
- Reset mid-operation:
  - Any outstanding downstream transaction is abandoned.
  - A later stray mem_done seen in IDLE is ignored.
- Storage:
  - Circular FIFO of {addr[31:0], data, mask}.
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count ranges 0..DEPTH.
  - There is no write merging.
- Request acceptance (cycle T, busy=0, rw_flag≠0):
  - Write with count<DEPTH: enqueued at the edge ending T; done=1 in T+1; busy stays 0.
  - Write with count==DEPTH: latched into the pending register; busy=1 from T+1. It is enqueued on the edge after the first write retirement, even if that retirement coincides with acceptance. done is pulsed one cycle later, and busy falls in the done cycle.
  - Read: latched into the pending register; busy=1 from T+1 until it falls in the done cycle.
  - busy is 0 in every done cycle, so a request may be presented in that same cycle.
- Read hazard:
  - Raised when a pending read's addr[31:2] matches addr[31:2] of any valid entry, or of the write currently outstanding downstream.
  - With READ_BYPASS=0, the hazard is simply count≠0 or a write outstanding.
- Downstream FSM:
  - IDLE:
    - When mem_busy=0, issue a request in the next cycle.
    - Priority: a pending read with no hazard goes first (mem_rw_flag=1, mem_addr=pending addr).
    - Otherwise the head entry if count>0: mem_rw_flag=2, mem_addr/data/mask from the head.
    - Then go to WAIT_READ or WAIT_WRITE.
    - mem_* outputs are registered and asserted for exactly one cycle; they are 0 otherwise.
  - WAIT_WRITE:
    - On mem_done: pop the head, decrement count, return to IDLE.
    - The head entry stays valid for hazard checks until mem_done.
  - WAIT_READ:
    - On mem_done: read_data ← mem_read_data, done=1 next cycle, busy=0 next cycle, pending cleared, return to IDLE.
- Read latency with no hazard, empty buffer and mem_busy=0:
  - Accepted in T, mem request in T+1.
  - mem_done in M, done in M+1.
- Invariants:
  - At most one downstream transaction is outstanding.
  - Writes retire in acceptance order.
- empty = (count==0) and not in WAIT_WRITE. It is used by software fences and by flush sequences.

Test Plan:
- Single write to 0x100, data 0xDEADBEEF, mask 0xF, with memory acking 3 cycles after issue → done in T+1. mem_rw_flag=2 once with matching addr/data/mask. empty returns to 1 after mem_done.
- Five back-to-back writes with DEPTH=4 and memory latency 5 → the first four get done one cycle after acceptance. The fifth raises busy and gets done one cycle after the enqueue that follows the first retirement. Memory sees addresses in issue order.
- Writes to 0x200 and 0x204 queued, then a read of 0x300 → the read is issued right after the in-flight write completes, before 0x204. read_data equals the memory value at done.
- Writes to 0x200 and 0x204 queued, then a read of 0x204 → the read stays pending until 0x204 is retired, then returns the just-written data. busy stays high throughout.
- READ_BYPASS=0 with three queued writes, then a read of an unrelated address → the read is issued only after the third write's mem_done.
- Assert RST while in WAIT_WRITE with two entries queued → busy=0, done=0, empty=1, all mem_* outputs 0. A subsequent mem_done is ignored, and a new write is accepted normally.
